// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg                                                             |
// | Shared UART definitions: RX FSM encoding, parity modes, baud helper. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff                                                             |
// | Single-bit two-flop synchroniser with configurable reset value.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_param                                                        |
// | Parametrised UART receiver with mid-bit sampling, parity/framing     |
// | checks and a single-entry valid/ready holding register.              |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 12000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 rx_enable,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int IDX_W        = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_EXP   = (PARITY == PAR_ODD);

  logic                 rxs;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 bit_tick;
  logic                 frame_done;
  logic                 frame_err_now;

  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q;
  logic                 parity_err_q;
  logic                 frame_err_q;
  logic                 overrun_q;

  sync_2ff #(
    .RST_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (rx),
    .q_o  (rxs)
  );

  assign bit_tick = (cnt_q == BIT_LAST);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    stop_idx_d    = stop_idx_q;
    shift_d       = shift_q;
    par_err_d     = par_err_q;
    frm_err_d     = frm_err_q;
    frame_done    = 1'b0;
    frame_err_now = frm_err_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_enable && !rxs) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        // A line that is high again at mid start bit was only a glitch.
        if (cnt_q == HALF_LAST) begin
          if (rxs) begin
            state_d = ST_IDLE;
          end else begin
            state_d    = ST_DATA;
            cnt_d      = '0;
            idx_d      = '0;
            stop_idx_d = 1'b0;
            par_err_d  = 1'b0;
            frm_err_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          cnt_d          = '0;
          shift_d[idx_q] = rxs;
          if (idx_q == IDX_LAST) begin
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (bit_tick) begin
          cnt_d     = '0;
          par_err_d = (((^shift_q) ^ rxs) != PAR_EXP);
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          cnt_d         = '0;
          frame_err_now = frm_err_q | ~rxs;
          frm_err_d     = frame_err_now;
          if (stop_idx_q == STOP_LAST) begin
            frame_done = 1'b1;
            state_d    = frame_err_now ? ST_WAIT_HIGH : ST_IDLE;
          end else begin
            stop_idx_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      stop_idx_q <= 1'b0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      stop_idx_q <= stop_idx_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
    end
  end

  // Holding register: a completing frame may replace data in the same cycle it is consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (frame_done) begin
        if (!rx_valid_q || rx_ready) begin
          rx_data_q    <= shift_q;
          parity_err_q <= par_err_q;
          frame_err_q  <= frame_err_now;
          rx_valid_q   <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (rx_valid_q && rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_param.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_param                                                     |
// | Directed bench: 8N1, 8E1 and 7N2 receivers driven from one clock.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_uart_rx_param;

  localparam int BIT = 104;

  typedef struct packed {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } cap_t;

  typedef struct {
    int         sel;
    logic [8:0] data;
    logic       par_bit;
    logic       stop_lvl;
    logic [8:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_ab, rst_n_c;
  logic       rx_a, rx_b, rx_c;
  logic       en_a, en_b, en_c;
  logic       ready_a, ready_b, ready_c;
  logic [7:0] rx_data_a, rx_data_b;
  logic [6:0] rx_data_c;
  logic       rx_valid_a, rx_valid_b, rx_valid_c;
  logic       parity_err_a, parity_err_b, parity_err_c;
  logic       frame_err_a, frame_err_b, frame_err_c;
  logic       overrun_a, overrun_b, overrun_c;

  uart_rx_param u_dut_a (
    .clk(clk), .rst_n(rst_n_ab), .rx(rx_a), .rx_enable(en_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(ready_a),
    .parity_err(parity_err_a), .frame_err(frame_err_a), .overrun(overrun_a)
  );

  uart_rx_param #(.PARITY(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n_ab), .rx(rx_b), .rx_enable(en_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(ready_b),
    .parity_err(parity_err_b), .frame_err(frame_err_b), .overrun(overrun_b)
  );

  uart_rx_param #(.DATA_BITS(7), .STOP_BITS(2)) u_dut_c (
    .clk(clk), .rst_n(rst_n_c), .rx(rx_c), .rx_enable(en_c),
    .rx_data(rx_data_c), .rx_valid(rx_valid_c), .rx_ready(ready_c),
    .parity_err(parity_err_c), .frame_err(frame_err_c), .overrun(overrun_c)
  );

  // Accepted-frame capture; only this block writes the capture stores.
  cap_t cap_a[64], cap_b[64], cap_c[64];
  int   wr_a = 0, wr_b = 0, wr_c = 0;
  int   ovr_a = 0, ovr_b = 0, ovr_c = 0;

  always @(negedge clk) begin
    if (rx_valid_a && ready_a) begin
      cap_a[wr_a % 64] = '{data: {1'b0, rx_data_a}, perr: parity_err_a, ferr: frame_err_a};
      wr_a++;
    end
    if (rx_valid_b && ready_b) begin
      cap_b[wr_b % 64] = '{data: {1'b0, rx_data_b}, perr: parity_err_b, ferr: frame_err_b};
      wr_b++;
    end
    if (rx_valid_c && ready_c) begin
      cap_c[wr_c % 64] = '{data: {2'b00, rx_data_c}, perr: parity_err_c, ferr: frame_err_c};
      wr_c++;
    end
    if (overrun_a) ovr_a++;
    if (overrun_b) ovr_b++;
    if (overrun_c) ovr_c++;
  end

  int   n_checks = 0;
  int   n_errors = 0;
  int   rd_a = 0, rd_b = 0, rd_c = 0;
  int   lat;
  int   ovr_base;
  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return wr_a - rd_a;
      1:       return wr_b - rd_b;
      default: return wr_c - rd_c;
    endcase
  endfunction

  task automatic qpop(input int sel, output cap_t c);
    case (sel)
      0:       begin c = cap_a[rd_a % 64]; rd_a++; end
      1:       begin c = cap_b[rd_b % 64]; rd_b++; end
      default: begin c = cap_c[rd_c % 64]; rd_c++; end
    endcase
  endtask

  task automatic flush(input int sel);
    case (sel)
      0:       rd_a = wr_a;
      1:       rd_b = wr_b;
      default: rd_c = wr_c;
    endcase
  endtask

  task automatic chk_frame(input string name, input int sel, input logic [8:0] ed,
                           input logic ep, input logic ef);
    cap_t c;
    if (qsize(sel) == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no frame expected data %0h", name, ed);
    end else begin
      qpop(sel, c);
      chk({name, " data"}, 32'(c.data), 32'(ed));
      chk({name, " perr"}, 32'(c.perr), 32'(ep));
      chk({name, " ferr"}, 32'(c.ferr), 32'(ef));
    end
  endtask

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Caller is negedge-aligned; returns negedge-aligned after the last stop bit.
  task automatic send(input int sel, input logic [8:0] data, input logic par_bit,
                      input logic stop_lvl);
    int nbits;
    int nstop;
    nbits = (sel == 2) ? 7 : 8;
    nstop = (sel == 2) ? 2 : 1;
    set_rx(sel, 1'b0);
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      set_rx(sel, data[i]);
      repeat (BIT) @(negedge clk);
    end
    if (sel == 1) begin
      set_rx(sel, par_bit);
      repeat (BIT) @(negedge clk);
    end
    for (int i = 0; i < nstop; i++) begin
      set_rx(sel, stop_lvl);
      repeat (BIT) @(negedge clk);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{0, 9'h05A, 1'b0, 1'b1, 9'h05A, 1'b0, 1'b0};
    vecs[1] = '{0, 9'h001, 1'b0, 1'b1, 9'h001, 1'b0, 1'b0};
    vecs[2] = '{0, 9'h080, 1'b0, 1'b1, 9'h080, 1'b0, 1'b0};
    vecs[3] = '{1, 9'h003, 1'b1, 1'b1, 9'h003, 1'b1, 1'b0};
    vecs[4] = '{1, 9'h003, 1'b0, 1'b1, 9'h003, 1'b0, 1'b0};
    vecs[5] = '{1, 9'h007, 1'b1, 1'b1, 9'h007, 1'b0, 1'b0};
    vecs[6] = '{1, 9'h007, 1'b0, 1'b1, 9'h007, 1'b1, 1'b0};
    vecs[7] = '{1, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b0};
    vecs[8] = '{2, 9'h055, 1'b0, 1'b1, 9'h055, 1'b0, 1'b0};
    vecs[9] = '{2, 9'h040, 1'b0, 1'b1, 9'h040, 1'b0, 1'b0};

    rst_n_ab = 1'b0; rst_n_c = 1'b0;
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    en_a = 1'b1; en_b = 1'b1; en_c = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1; ready_c = 1'b0;
    #1;
    chk("reset rx_data", 32'(rx_data_a), 32'h0);
    chk("reset rx_valid", 32'(rx_valid_a), 32'h0);
    chk("reset parity_err", 32'(parity_err_a), 32'h0);
    chk("reset frame_err", 32'(frame_err_a), 32'h0);
    chk("reset overrun", 32'(overrun_a), 32'h0);
    repeat (5) @(negedge clk);
    rst_n_ab = 1'b1; rst_n_c = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle rx_valid", 32'(rx_valid_a), 32'h0);

    // 8N1 latency: rx_valid observed after the 991st rising edge following the fall
    lat = -1;
    fork
      send(0, 9'h0A5, 1'b0, 1'b1);
      begin
        for (int k = 1; k <= 1200; k++) begin
          @(posedge clk); #1;
          if (rx_valid_a) begin
            lat = k;
            break;
          end
        end
        chk("latency A5", 32'(lat), 32'd991);
        chk("latency A5 data", 32'(rx_data_a), 32'h0A5);
        chk("latency A5 perr", 32'(parity_err_a), 32'h0);
        chk("latency A5 ferr", 32'(frame_err_a), 32'h0);
      end
    join
    repeat (5) @(negedge clk);
    flush(0);

    send(0, 9'h000, 1'b0, 1'b1);
    send(0, 9'h0FF, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("b2b count", 32'(qsize(0)), 32'd2);
    chk_frame("b2b first", 0, 9'h000, 1'b0, 1'b0);
    chk_frame("b2b second", 0, 9'h0FF, 1'b0, 1'b0);

    rx_a = 1'b0;
    repeat (20) @(negedge clk);
    rx_a = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch no frame", 32'(qsize(0)), 32'd0);
    send(0, 9'h03C, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk_frame("after glitch", 0, 9'h03C, 1'b0, 1'b0);

    en_a = 1'b0;
    send(0, 9'h000, 1'b0, 1'b1);
    repeat (20) @(negedge clk);
    en_a = 1'b1;
    chk("disabled no frame", 32'(qsize(0)), 32'd0);

    // Stop bit low, then a stuck-low line must not start a new frame
    send(0, 9'h081, 1'b0, 1'b0);
    repeat (500) @(negedge clk);
    chk_frame("framing", 0, 9'h081, 1'b0, 1'b1);
    chk("stuck low valid", 32'(rx_valid_a), 32'h0);
    rx_a = 1'b1;
    repeat (20) @(negedge clk);
    send(0, 9'h055, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk_frame("after break", 0, 9'h055, 1'b0, 1'b0);
    chk("after break extra", 32'(qsize(0)), 32'd0);

    ready_a  = 1'b0;
    ovr_base = ovr_a;
    send(0, 9'h011, 1'b0, 1'b1);
    send(0, 9'h022, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk("overrun pulses", 32'(ovr_a - ovr_base), 32'd1);
    chk("overrun valid", 32'(rx_valid_a), 32'h1);
    chk("overrun data", 32'(rx_data_a), 32'h011);
    ready_a = 1'b1;
    @(posedge clk); #1;
    chk("release valid", 32'(rx_valid_a), 32'h0);
    chk("release data hold", 32'(rx_data_a), 32'h011);
    @(negedge clk);
    flush(0);

    // 7N2: asynchronous reset in the middle of the data bits
    send(2, 9'h015, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("7n2 held valid", 32'(rx_valid_c), 32'h1);
    chk("7n2 held data", 32'(rx_data_c), 32'h15);
    fork
      send(2, 9'h07F, 1'b0, 1'b1);
      begin
        repeat (400) @(negedge clk);
        #2;
        rst_n_c = 1'b0;
        #1;
        chk("midreset valid", 32'(rx_valid_c), 32'h0);
        chk("midreset data", 32'(rx_data_c), 32'h0);
        chk("midreset perr", 32'(parity_err_c), 32'h0);
        chk("midreset ferr", 32'(frame_err_c), 32'h0);
        repeat (3) @(negedge clk);
        rst_n_c = 1'b1;
      end
    join
    repeat (50) @(negedge clk);
    chk("midreset no delivery", 32'(rx_valid_c), 32'h0);
    ready_c = 1'b1;
    send(2, 9'h02A, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    chk_frame("7n2 after reset", 2, 9'h02A, 1'b0, 1'b0);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].sel, vecs[i].data, vecs[i].par_bit, vecs[i].stop_lvl);
      repeat (10) @(negedge clk);
      chk_frame($sformatf("vec%0d", i), vecs[i].sel, vecs[i].exp_data,
                vecs[i].exp_perr, vecs[i].exp_ferr);
    end

    chk("no overrun b", 32'(ovr_b), 32'd0);
    chk("no overrun c", 32'(ovr_c), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver and the next generation of the icestick UART RX path. Adds the following:
- Two-flop input synchroniser.
- Mid-bit sampling with false-start rejection.
- Configurable data width, parity and stop bits.
- Parity and framing error reporting.
- Single-entry output holding register with valid/ready handshake and overrun detection.

It sits between the FPGA rx pin and the command parser, running on the 12 MHz board clock.

Parameters:
CLK_HZ, 12000000, system clock frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (104 at defaults, integer division), HALF_BIT = CLKS_PER_BIT/2 (52)
DATA_BITS, 8, payload bits per frame; legal range 5..9; sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2

Ports:
clk  in  1  system clock; all logic on the rising edge
rst_n  in  1  asynchronous, active-low reset
rx  in  1  raw serial line; idles high; asynchronous to clk
rx_enable  in  1  high permits detection of a new start bit
rx_data  out  DATA_BITS  received payload; valid while rx_valid=1
rx_valid  out  1  holding register full
rx_ready  in  1  consumer accepts rx_data on a cycle where rx_valid && rx_ready
parity_err  out  1  parity mismatch on the held frame; qualified by rx_valid
frame_err  out  1  a stop bit was sampled low on the held frame; qualified by rx_valid
overrun  out  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Reset (async assert, sync release): synchroniser flops = 1, state = IDLE, counters = 0. Outputs: rx_data = 0, rx_valid = 0, parity_err = 0, frame_err = 0, overrun = 0. Reset asserted mid-frame aborts the frame; no partial data is delivered.
- Synchroniser: rx passes through 2 flops. All decisions use the synchronised signal rxs (2-cycle delay from the pin).
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - rx_enable && rxs == 0 -> START, counter cleared.
  - rx_enable is sampled only here. Deasserting it mid-frame does not abort the frame.
- START:
  - Counter counts to HALF_BIT-1, then samples rxs.
  - rxs == 1 -> false start -> IDLE.
  - Otherwise -> DATA, counter cleared, bit index cleared.
- DATA:
  - Sample rxs every CLKS_PER_BIT cycles into shift position bit_idx.
  - After DATA_BITS samples -> PARITY if PARITY != 0, else STOP.
- PARITY:
  - One sample.
  - Error if (XOR of data bits XOR sampled bit) != (PARITY == 1 ? 1 : 0).
- STOP:
  - STOP_BITS samples; any low sample sets the frame error.
  - After the last stop sample:
    - If frame error -> WAIT_HIGH.
    - Else -> IDLE.
  - In both cases the frame is delivered (see holding register).
- WAIT_HIGH:
  - Remain until rxs == 1 (break / stuck-low line), then -> IDLE.
  - Prevents a held-low line retriggering start detection.
- Latency: rx_valid rises exactly 1 clock after the final stop-bit sample. For 8N1 at defaults that is 2 + 52 + 9*104 + 1 = 991 clocks after the rx pin falling edge.
- Holding register:
  - On frame completion with rx_valid == 0, or with rx_valid && rx_ready in that same cycle: load rx_data, parity_err and frame_err, and set rx_valid.
  - On frame completion with rx_valid && !rx_ready: keep the old data, pulse overrun for 1 cycle, and discard the new frame.
  - rx_valid && rx_ready with no completing frame: clear rx_valid. rx_data and the error flags hold their last value.
- Counter width: clog2(CLKS_PER_BIT). No wrap-around beyond CLKS_PER_BIT-1 is permitted.
- The receiver keeps receiving while rx_valid is high; only delivery is blocked.

Decomposition:
- Package uart_pkg:
  - FSM state enum.
  - Parity mode constants (PAR_NONE/PAR_ODD/PAR_EVEN).
  - Function for CLKS_PER_BIT from CLK_HZ/BAUD; shared with the future uart_tx_param.
- Sub-module sync_2ff (1-bit two-flop synchroniser, async reset value parameter). Reused for other pin inputs.

Test Plan:
- 8N1 at defaults, rx_ready held 1, send 0xA5 -> rx_valid at clock 991 after the falling edge, rx_data = 0xA5, parity_err = 0, frame_err = 0; send 0x00 and 0xFF back-to-back -> both delivered in order.
- 20-cycle low glitch on an idle line -> no rx_valid; FSM back in IDLE; a following valid frame 0x3C is received correctly.
- PARITY = 2 (even), send 0x03 with parity bit 1 -> rx_data = 0x03, parity_err = 1; resend with parity bit 0 -> parity_err = 0.
- Stop bit driven 0, then line held low 500 cycles -> one frame with frame_err = 1, no further rx_valid until the line returns high; next frame 0x55 received clean.
- rx_ready = 0, send 0x11 then 0x22 -> rx_data stays 0x11, one-cycle overrun pulse at completion of 0x22; raise rx_ready -> rx_valid drops the next cycle.
- DATA_BITS = 7, STOP_BITS = 2, rst_n pulsed low mid-DATA of frame 0x7F -> outputs zero immediately, no delivery; next frame 0x2A received as 0x2A.
